// File: rtl/burst_replay_buffer.sv
// Captures one contiguous burst into a single-port RAM, then replays it forward
// or reversed through a 2-entry skid stage with valid/ready back-pressure.
module burst_replay_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rev_mode,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   burst_len
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;
  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] mem_q;

  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   rd_cnt_q;
  logic              ovf_q;
  logic              rev_q;
  logic              rd_pend_q;
  logic              rd_pend_last_q;

  logic [DATA_W-1:0] skid_data [2];
  logic [1:0]        skid_last;
  logic              skid_wr_q;
  logic              skid_rd_q;
  logic [1:0]        skid_cnt_q;

  logic              wr_en;
  logic              rd_en;
  logic              push;
  logic              pop;
  logic              last_pop;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] ram_addr;
  logic [2:0]        skid_room_use;

  assign pop      = (skid_cnt_q != 2'd0) && out_ready;
  assign push     = rd_pend_q;
  assign last_pop = pop && skid_last[skid_rd_q];

  // A read is only issued if its data is guaranteed a skid slot when it lands.
  assign skid_room_use = {1'b0, skid_cnt_q} + {2'b0, rd_pend_q} - {2'b0, pop};
  assign rd_en = (state_q == S_DRAIN) && (rd_cnt_q < len_q) && (skid_room_use < 3'd2);
  assign wr_en = in_valid && ((state_q == S_IDLE) ||
                              ((state_q == S_CAPTURE) && (len_q < DEPTH_V)));

  assign rd_idx   = rev_q ? ADDR_W'(len_q - rd_cnt_q - 1'b1) : ADDR_W'(rd_cnt_q);
  assign ram_addr = (state_q == S_DRAIN) ? rd_idx :
                    (state_q == S_IDLE)  ? '0 : len_q[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q != S_DRAIN);
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE:    if (in_valid)  state_d = S_CAPTURE;
      S_CAPTURE: if (!in_valid) state_d = S_DRAIN;
      S_DRAIN:   if (last_pop)  state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0;
      ovf_q <= 1'b0;
      rev_q <= 1'b0;
    end else if ((state_q == S_IDLE) && in_valid) begin
      len_q <= (ADDR_W+1)'(1);
      ovf_q <= 1'b0;
      rev_q <= rev_mode;
    end else if ((state_q == S_CAPTURE) && in_valid) begin
      if (len_q < DEPTH_V) len_q <= len_q + 1'b1;
      else                 ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[ram_addr] <= in_data;
    if (rd_en) mem_q <= mem[ram_addr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q       <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      rd_pend_q      <= rd_en;
      rd_pend_last_q <= rd_en && (rd_cnt_q == len_q - 1'b1);
      if (state_q != S_DRAIN) rd_cnt_q <= '0;
      else if (rd_en)         rd_cnt_q <= rd_cnt_q + 1'b1;
    end
  end

  // Skid pointers/occupancy; payload storage needs no reset since out_* are gated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      if (push) skid_wr_q <= ~skid_wr_q;
      if (pop)  skid_rd_q <= ~skid_rd_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skid_data[skid_wr_q] <= mem_q;
      skid_last[skid_wr_q] <= rd_pend_last_q;
    end
  end

  assign out_valid = (skid_cnt_q != 2'd0);
  assign out_data  = out_valid ? skid_data[skid_rd_q] : '0;
  assign out_last  = out_valid && skid_last[skid_rd_q];
  assign overflow  = ovf_q;
  assign burst_len = len_q;

endmodule
